// File: rtl/cnn_router_pkg.sv
// Shared types and constants for the CNN bank write router.
package cnn_router_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } router_state_t;

  localparam logic MODE_EXPLICIT = 1'b0;
  localparam logic MODE_AUTO     = 1'b1;

endpackage

// File: rtl/bank_fill_counter.sv
// Saturating per-bank fill counter; full flags that DEPTH writes have landed.
module bank_fill_counter #(
  parameter int DEPTH = 120,
  parameter int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             inc,
  output logic [CNT_W-1:0] count,
  output logic             full
);

  logic [CNT_W-1:0] r_count;

  assign full  = (r_count == CNT_W'(DEPTH));
  assign count = r_count;

  // Count accepted writes; clr wins over inc, and the count holds at DEPTH.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)              r_count <= '0;
    else if (clr)         r_count <= '0;
    else if (inc && !full) r_count <= r_count + CNT_W'(1);
  end

endmodule

// File: rtl/cnn_bank_write_router.sv
// Registered N-way write router: steers one write port to one of NUM_CH
// bank ports, by explicit select or by an in-order auto fill sequencer.
module cnn_bank_write_router
  import cnn_router_pkg::*;
#(
  parameter int DATA_W   = 16,
  parameter int ADDR_W   = 16,
  parameter int NUM_CH   = 4,
  parameter int CH_DEPTH = 120,
  parameter int SEL_W    = $clog2(NUM_CH)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic                     mode,
  input  logic                     we,
  input  logic [DATA_W-1:0]        data,
  input  logic [ADDR_W-1:0]        addr,
  input  logic [SEL_W-1:0]         select,
  output logic [NUM_CH-1:0]        we_o,
  output logic [NUM_CH*DATA_W-1:0] data_o,
  output logic [NUM_CH*ADDR_W-1:0] addr_o,
  output logic [SEL_W-1:0]         cur_ch,
  output logic [NUM_CH-1:0]        ch_full,
  output logic                     all_done,
  output logic                     err
);

  localparam int CNT_W = $clog2(CH_DEPTH + 1);
  // One extra bit so the range checks still work when 2**ADDR_W == CH_DEPTH
  // or NUM_CH is a power of two.
  localparam logic [ADDR_W:0] DEPTH_A = (ADDR_W + 1)'(CH_DEPTH);
  localparam logic [SEL_W:0]  NCH_S   = (SEL_W + 1)'(NUM_CH);
  localparam logic [SEL_W:0]  LAST_S  = (SEL_W + 1)'(NUM_CH - 1);

  router_state_t r_state, w_state_nxt;

  logic [NUM_CH-1:0][CNT_W-1:0] w_count;
  logic [NUM_CH-1:0]            w_full;
  logic [NUM_CH-1:0]            w_inc;
  logic [NUM_CH-1:0]            w_full_nxt;

  logic [SEL_W-1:0]  r_cur_ch;
  logic              r_err;
  logic [NUM_CH-1:0]        r_we_o;
  logic [NUM_CH*DATA_W-1:0] r_data_o;
  logic [NUM_CH*ADDR_W-1:0] r_addr_o;

  logic [SEL_W-1:0]         w_ch;
  logic                     w_ch_ok;
  logic                     w_tgt_full;
  logic                     w_illegal;
  logic                     w_req;
  logic                     w_acc;
  logic                     w_err_set;
  logic                     w_fill_last;
  logic [ADDR_W-1:0]        w_addr_sel;
  logic [NUM_CH*DATA_W-1:0] w_data_o;
  logic [NUM_CH*ADDR_W-1:0] w_addr_o;

  // One fill counter per bank, cleared by start.
  for (genvar g = 0; g < NUM_CH; g++) begin : g_cnt
    bank_fill_counter #(.DEPTH(CH_DEPTH), .CNT_W(CNT_W)) u_cnt (
      .clk   (clk),
      .rst   (rst),
      .clr   (start),
      .inc   (w_inc[g]),
      .count (w_count[g]),
      .full  (w_full[g])
    );
  end

  // Resolve target channel/address and classify the request as accepted,
  // dropped with error, or silently ignored.
  always_comb begin
    w_ch        = (mode == MODE_AUTO) ? r_cur_ch : select;
    w_ch_ok     = ({1'b0, w_ch} < NCH_S);
    w_tgt_full  = w_ch_ok ? w_full[w_ch] : 1'b0;
    w_addr_sel  = (mode == MODE_AUTO) ? ADDR_W'(w_count[w_ch]) : addr;
    w_illegal   = (mode == MODE_AUTO) ? w_tgt_full
                : (!w_ch_ok || ({1'b0, addr} >= DEPTH_A) || w_tgt_full);
    // start takes priority: a coincident write is neither accepted nor an error.
    w_req       = we && !start;
    w_acc       = w_req && (r_state == RUN) && !w_illegal;
    w_err_set   = w_req && (((r_state == RUN) && w_illegal) || (r_state == DONE));
    w_inc       = w_acc ? (NUM_CH'(1) << w_ch) : '0;
    w_fill_last = w_acc && (w_count[w_ch] == CNT_W'(CH_DEPTH - 1));
    w_full_nxt  = w_full | (w_fill_last ? w_inc : '0);
  end

  // Next-state: start restarts from any state; the write that fills the
  // last open bank ends the run.
  always_comb begin
    w_state_nxt = r_state;
    if (start)
      w_state_nxt = RUN;
    else if ((r_state == RUN) && w_acc && (&w_full_nxt))
      w_state_nxt = DONE;
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_nxt;
  end

  // Build per-channel data/address; idle channels are driven to zero.
  always_comb begin
    w_data_o = '0;
    w_addr_o = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      if (w_inc[k]) begin
        w_data_o[k*DATA_W +: DATA_W] = data;
        w_addr_o[k*ADDR_W +: ADDR_W] = w_addr_sel;
      end
    end
  end

  // Output registers: one-cycle latency from input sample to bank port.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_we_o   <= '0;
      r_data_o <= '0;
      r_addr_o <= '0;
    end else begin
      r_we_o   <= w_inc;
      r_data_o <= w_data_o;
      r_addr_o <= w_addr_o;
    end
  end

  // Auto pointer: advance only when an auto write fills the current bank,
  // holding at the last channel.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      r_cur_ch <= '0;
    else if (start)
      r_cur_ch <= '0;
    else if (w_fill_last && (mode == MODE_AUTO) && ({1'b0, r_cur_ch} != LAST_S))
      r_cur_ch <= r_cur_ch + SEL_W'(1);
  end

  // Sticky error for dropped writes; only start or reset clear it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)            r_err <= 1'b0;
    else if (start)     r_err <= 1'b0;
    else if (w_err_set) r_err <= 1'b1;
  end

  assign we_o     = r_we_o;
  assign data_o   = r_data_o;
  assign addr_o   = r_addr_o;
  assign cur_ch   = r_cur_ch;
  assign ch_full  = w_full;
  assign all_done = (r_state == DONE);
  assign err      = r_err;

endmodule

// File: tb/tb_cnn_bank_write_router.sv
// Directed bench for cnn_bank_write_router (4-channel and 5-channel builds).
module tb_cnn_bank_write_router;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        start, mode, we;
  logic [15:0] data, addr;
  logic [1:0]  select;
  logic [3:0]  we_o, ch_full;
  logic [63:0] data_o, addr_o;
  logic [1:0]  cur_ch;
  logic        all_done, err;

  logic        start5, we5;
  logic [2:0]  select5;
  logic [4:0]  we_o5, ch_full5;
  logic [79:0] data_o5, addr_o5;
  logic [2:0]  cur_ch5;
  logic        all_done5, err5;

  int n_chk  = 0;
  int n_fail = 0;

  cnn_bank_write_router #(.DATA_W(16), .ADDR_W(16), .NUM_CH(4), .CH_DEPTH(120)) u_dut (
    .clk(clk), .rst(rst), .start(start), .mode(mode), .we(we), .data(data),
    .addr(addr), .select(select), .we_o(we_o), .data_o(data_o), .addr_o(addr_o),
    .cur_ch(cur_ch), .ch_full(ch_full), .all_done(all_done), .err(err)
  );

  cnn_bank_write_router #(.DATA_W(16), .ADDR_W(16), .NUM_CH(5), .CH_DEPTH(120)) u_dut5 (
    .clk(clk), .rst(rst), .start(start5), .mode(mode), .we(we5), .data(data),
    .addr(addr), .select(select5), .we_o(we_o5), .data_o(data_o5), .addr_o(addr_o5),
    .cur_ch(cur_ch5), .ch_full(ch_full5), .all_done(all_done5), .err(err5)
  );

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int ch;
    start = 0; mode = 0; we = 0; data = '0; addr = '0; select = '0;
    start5 = 0; we5 = 0; select5 = '0;

    // reset values
    #12;
    chk("rst_we", 64'(we_o), 64'h0);
    chk("rst_data", data_o, 64'h0);
    chk("rst_addr", addr_o, 64'h0);
    chk("rst_cur", 64'(cur_ch), 64'h0);
    chk("rst_full", 64'(ch_full), 64'h0);
    chk("rst_done", 64'(all_done), 64'h0);
    chk("rst_err", 64'(err), 64'h0);
    chk("rst5_we", 64'(we_o5), 64'h0);
    chk("rst5_misc", {34'h0, data_o5[15:0], addr_o5[7:0], cur_ch5, ch_full5, all_done5},
        64'h0);
    @(negedge clk) rst = 0;

    // write in IDLE is silently dropped
    we = 1; mode = 0; select = 2'd2; addr = 16'd5; data = 16'h1111;
    step();
    chk("idle_we", 64'(we_o), 64'h0);
    chk("idle_err", 64'(err), 64'h0);
    we = 0;

    // explicit write to channel 2
    start = 1; step(); start = 0;
    we = 1; select = 2'd2; addr = 16'd5; data = 16'hABCD;
    step();
    chk("ex_we", 64'(we_o), 64'h4);
    chk("ex_data", data_o, 64'h0000_ABCD_0000_0000);
    chk("ex_addr", addr_o, 64'h0000_0005_0000_0000);
    we = 0;
    step();
    chk("ex_we_off", 64'(we_o), 64'h0);
    chk("ex_data_off", data_o, 64'h0);

    // auto fill of all four banks
    start = 1; step(); start = 0;
    mode = 1; we = 1; addr = 16'hFFFF; select = 2'd1;
    for (int i = 0; i < 480; i++) begin
      data = 16'(i + 256);
      step();
      ch = i / 120;
      chk("af_we", 64'(we_o), 64'(1) << ch);
      chk("af_addr", addr_o, 64'(i % 120) << (16 * ch));
      chk("af_data", data_o, 64'(i + 256) << (16 * ch));
      if ((i + 1) % 120 == 0) begin
        chk("af_cur", 64'(cur_ch), 64'(((i + 1) / 120 > 3) ? 3 : (i + 1) / 120));
        chk("af_full", 64'(ch_full), (64'(1) << ((i + 1) / 120)) - 64'(1));
      end
    end
    chk("af_done", 64'(all_done), 64'h1);
    chk("af_err0", 64'(err), 64'h0);
    step();
    chk("af481_we", 64'(we_o), 64'h0);
    chk("af481_err", 64'(err), 64'h1);
    chk("af481_done", 64'(all_done), 64'h1);
    we = 0;

    // start from DONE
    start = 1; step(); start = 0;
    chk("rs_done", 64'(all_done), 64'h0);
    chk("rs_err", 64'(err), 64'h0);
    chk("rs_full", 64'(ch_full), 64'h0);
    chk("rs_cur", 64'(cur_ch), 64'h0);

    // start with we mid-run: counters clear, no error
    mode = 1; we = 1;
    step(); step(); step();
    chk("sw_addr2", addr_o, 64'h2);
    start = 1; step(); start = 0;
    chk("sw_we", 64'(we_o), 64'h0);
    chk("sw_err", 64'(err), 64'h0);
    step();
    chk("sw_we_next", 64'(we_o), 64'h1);
    chk("sw_addr_next", addr_o, 64'h0);
    we = 0;

    // explicit address out of range
    mode = 0; select = 2'd1; addr = 16'd120; we = 1;
    step();
    chk("bad_addr_we", 64'(we_o), 64'h0);
    chk("bad_addr_err", 64'(err), 64'h1);
    we = 0;

    // explicit write to a full bank
    start = 1; step(); start = 0;
    select = 2'd3; we = 1;
    for (int a = 0; a < 120; a++) begin
      addr = 16'(a);
      step();
    end
    chk("fb_last_we", 64'(we_o), 64'h8);
    chk("fb_full", 64'(ch_full), 64'h8);
    chk("fb_err0", 64'(err), 64'h0);
    addr = 16'd0;
    step();
    chk("fb_we", 64'(we_o), 64'h0);
    chk("fb_err", 64'(err), 64'h1);
    we = 0;

    // mode switch: 10 auto writes then explicit fill of channel 0
    start = 1; step(); start = 0;
    mode = 1; we = 1;
    for (int i = 0; i < 10; i++) step();
    chk("ms_auto_addr", addr_o, 64'd9);
    mode = 0; select = 2'd0;
    for (int a = 10; a < 120; a++) begin
      addr = 16'(a);
      step();
    end
    chk("ms_full", 64'(ch_full), 64'h1);
    chk("ms_cur", 64'(cur_ch), 64'h0);
    chk("ms_err0", 64'(err), 64'h0);
    mode = 1;
    step();
    chk("ms_auto_we", 64'(we_o), 64'h0);
    chk("ms_auto_err", 64'(err), 64'h1);
    chk("ms_auto_cur", 64'(cur_ch), 64'h0);
    we = 0;

    // async reset between edges during a burst
    start = 1; step(); start = 0;
    mode = 1; we = 1; data = 16'h5A5A;
    step(); step();
    chk("ar_pre_we", 64'(we_o), 64'h1);
    #2 rst = 1;
    #1;
    chk("ar_we", 64'(we_o), 64'h0);
    chk("ar_data", data_o, 64'h0);
    chk("ar_addr", addr_o, 64'h0);
    @(negedge clk) rst = 0;
    step();
    chk("ar_post_we", 64'(we_o), 64'h0);
    chk("ar_post_err", 64'(err), 64'h0);
    chk("ar_post_done", 64'(all_done), 64'h0);
    we = 0;

    // 5-channel build: out-of-range select
    mode = 0;
    start5 = 1; step(); start5 = 0;
    select5 = 3'd5; addr = 16'd0; we5 = 1;
    step();
    chk("s5_sel5_we", 64'(we_o5), 64'h0);
    chk("s5_sel5_err", 64'(err5), 64'h1);
    we5 = 0;
    start5 = 1; step(); start5 = 0;
    select5 = 3'd4; addr = 16'd7; data = 16'h1234; we5 = 1;
    step();
    chk("s5_sel4_we", 64'(we_o5), 64'h10);
    chk("s5_sel4_addr", 64'(addr_o5[79:64]), 64'h7);
    chk("s5_sel4_data", 64'(data_o5[79:64]), 64'h1234);
    chk("s5_sel4_err", 64'(err5), 64'h0);
    select5 = 3'd7;
    step();
    chk("s5_sel7_we", 64'(we_o5), 64'h0);
    chk("s5_sel7_err", 64'(err5), 64'h1);
    we5 = 0;

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
